rv32m_div_sequencer: RTL and testbench
======================================

RV32M_DIV_SEQUENCER -- requirements
Module: rv32m_div_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 The block SHALL have input i_valid, 1 bit: divide request from the execute stage.
REQ-003 The block SHALL have input i_funct3, 3 bits: 100 DIV, 101 DIVU, 110 REM, 111 REMU; 0xx is treated as DIVU.
REQ-004 The block SHALL have inputs i_rs1 and i_rs2, 32 bits each: dividend and divisor.
REQ-005 The block SHALL have input i_flush, 1 bit: kill the operation in flight.
REQ-006 The block SHALL have output o_busy, 1 bit: pipeline stall request.
REQ-007 The block SHALL have output o_valid, 1 bit: result strobe, single cycle.
REQ-008 The block SHALL have output o_result, 32 bits: quotient or remainder.

Function
REQ-009 The block SHALL implement the FSM states IDLE, CALC and DONE.
REQ-010 In IDLE, when i_valid=1 and i_flush=0 at a clock edge, the block SHALL latch operands and funct3 (accept) and go to CALC, or to DONE on the special or hit paths.
REQ-011 Signed ops SHALL divide |rs1| by |rs2|; the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of rs1.
REQ-012 CALC SHALL perform one restoring shift-subtract iteration per cycle for exactly 32 cycles, counted by a 5-bit counter that wraps 31->0 on the transition to DONE.
REQ-013 A normal op SHALL assert o_valid in the 33rd cycle after the accept edge, with o_result valid in that same cycle.
REQ-014 On divisor 0, the block SHALL go IDLE->DONE: quotient 0xFFFFFFFF and remainder rs1, for both signed and unsigned ops.
REQ-015 On signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF), the block SHALL go IDLE->DONE: quotient 0x80000000 and remainder 0.
REQ-016 DONE SHALL last exactly one cycle with o_valid=1, then return to IDLE.
REQ-017 o_busy SHALL be 1 in CALC and DONE, and also combinationally in IDLE when i_valid=1 and i_flush=0.
REQ-018 i_valid SHALL be ignored outside IDLE, and operand changes after acceptance SHALL have no effect.
REQ-019 i_flush=1 in any state SHALL force IDLE at the next edge, suppress o_valid in that cycle, and leave no result emitted.
REQ-020 When i_valid and i_flush are both 1 in IDLE, flush SHALL win and the request SHALL NOT be accepted.
REQ-021 Outside DONE, o_valid SHALL be 0 and o_result SHALL be 0.

Reset
REQ-022 rst=1 SHALL force IDLE, clear the counter, and set o_valid=0, o_busy=0 and o_result=0 at the next edge; this applies in any state, including mid-CALC.
REQ-023 rst SHALL have priority over i_flush and i_valid.
REQ-024 rst SHALL clear all internal operand and remainder registers to 0.

Configuration
REQ-025 The block SHALL support the macro DIV_RESULT_CACHE_EN.
REQ-026 With DIV_RESULT_CACHE_EN defined, the block SHALL hold registers for the last completed dividend, divisor, signedness, quotient, remainder and a valid bit. An accept matching all three keys SHALL go IDLE->DONE, with o_valid in the cycle after accept, so that a DIV then REM pair costs 33+1 cycles.
REQ-027 With DIV_RESULT_CACHE_EN defined, the cache SHALL be written only on DONE, never on a flushed op. rst SHALL clear the valid bit.
REQ-028 Without DIV_RESULT_CACHE_EN, no cache registers SHALL exist, and every non-special op SHALL take the full 33 cycles.

Structure
REQ-029 The shared package rv32m_pkg SHALL hold the state enum, the FUNCT3_DIV/DIVU/REM/REMU constants and DIV_ITERATIONS=32.
REQ-030 The sub-module rv32m_div_step SHALL be a combinational single restoring iteration: input {rem, quot, divisor}, output {rem', quot'}. The sequencer SHALL own all state.

Verification
REQ-031 DIVU 100/7 -> o_valid at cycle 33, o_result 14; REMU with the same operands -> 2.
REQ-032 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM with the same operands -> 0xFFFFFFFF (-1).
REQ-033 DIV x/0 -> 0xFFFFFFFF in the cycle after accept; REM 0x80000000 / 0xFFFFFFFF -> 0 in the cycle after accept.
REQ-034 Accept, pulse i_flush at CALC cycle 10 -> IDLE next cycle, no o_valid; then assert rst at CALC cycle 20 of a new op -> all outputs 0 next cycle.
REQ-035 i_valid held high with new operands during CALC -> ignored; the result matches the originally latched operands.
REQ-036 With DIV_RESULT_CACHE_EN, DIV 1000/3 then REM 1000/3 -> 333 at cycle 33, then 1 one cycle after the second accept.

Source files
------------

// File: rtl/rv32m_pkg.sv
// ============================================================================
// Module      : rv32m_pkg
// Description : Shared types and constants for the RV32M divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32m_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    localparam int DIV_ITERATIONS = 32;

    // Magnitude of a value that is only two's-complement when sgn is set.
    function automatic logic [31:0] abs_if_signed(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32m_div_step.sv
// ============================================================================
// Module      : rv32m_div_step
// Description : One combinational restoring shift-subtract divide iteration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32m_div_step (
    input  logic [31:0] i_rem,
    input  logic [31:0] i_quot,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_rem,
    output logic [31:0] o_quot
);

    logic [32:0] w_shifted;
    logic [33:0] w_diff;

    always_comb begin
        w_shifted = {i_rem, i_quot[31]};
        w_diff    = {1'b0, w_shifted} - {2'b00, i_divisor};
        // Bit 33 is the borrow: set means the trial subtract must be undone.
        if (w_diff[33]) begin
            o_rem  = w_shifted[31:0];
            o_quot = {i_quot[30:0], 1'b0};
        end else begin
            o_rem  = w_diff[31:0];
            o_quot = {i_quot[30:0], 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/rv32m_div_sequencer.sv
// ============================================================================
// Module      : rv32m_div_sequencer
// Description : Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer (32 iterations).
//               Optional last-result cache enabled by DIV_RESULT_CACHE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32m_div_sequencer
    import rv32m_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic        i_flush,
    output logic        o_busy,
    output logic        o_valid,
    output logic [31:0] o_result
);

    localparam logic [4:0] c_last_iter = 5'(DIV_ITERATIONS - 1);

    div_state_e  r_state;
    div_state_e  w_state_next;
    logic [4:0]  r_count;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic        r_signed;
    logic        r_is_rem;
    logic [31:0] r_rem;
    logic [31:0] r_quot;
    logic [31:0] r_divisor;
    logic [31:0] r_q_final;
    logic [31:0] r_r_final;

    logic        w_accept;
    logic        w_signed;
    logic        w_is_rem;
    logic        w_div_zero;
    logic        w_overflow;
    logic        w_hit;
    logic        w_calc_last;
    logic        w_neg_q;
    logic        w_neg_r;
    logic [31:0] w_rem_next;
    logic [31:0] w_quot_next;
    logic [31:0] w_hit_q;
    logic [31:0] w_hit_r;

    assign w_accept    = (r_state == ST_IDLE) && i_valid && !i_flush;
    assign w_signed    = (i_funct3 == FUNCT3_DIV) || (i_funct3 == FUNCT3_REM);
    assign w_is_rem    = (i_funct3 == FUNCT3_REM) || (i_funct3 == FUNCT3_REMU);
    assign w_div_zero  = (i_rs2 == 32'd0);
    assign w_overflow  = w_signed && (i_rs1 == 32'h8000_0000) && (i_rs2 == 32'hFFFF_FFFF);
    assign w_calc_last = (r_count == c_last_iter);
    assign w_neg_q     = r_signed && (r_rs1[31] ^ r_rs2[31]);
    assign w_neg_r     = r_signed && r_rs1[31];

    rv32m_div_step u_step (
        .i_rem     (r_rem),
        .i_quot    (r_quot),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_next),
        .o_quot    (w_quot_next)
    );

`ifdef DIV_RESULT_CACHE_EN
    logic        r_c_valid;
    logic [31:0] r_c_rs1;
    logic [31:0] r_c_rs2;
    logic        r_c_signed;
    logic [31:0] r_c_q;
    logic [31:0] r_c_r;

    assign w_hit   = r_c_valid && (i_rs1 == r_c_rs1) && (i_rs2 == r_c_rs2) && (w_signed == r_c_signed);
    assign w_hit_q = r_c_q;
    assign w_hit_r = r_c_r;

    // Only results that were actually delivered are remembered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_valid  <= 1'b0;
            r_c_rs1    <= 32'd0;
            r_c_rs2    <= 32'd0;
            r_c_signed <= 1'b0;
            r_c_q      <= 32'd0;
            r_c_r      <= 32'd0;
        end else if (r_state == ST_DONE && !i_flush) begin
            r_c_valid  <= 1'b1;
            r_c_rs1    <= r_rs1;
            r_c_rs2    <= r_rs2;
            r_c_signed <= r_signed;
            r_c_q      <= r_q_final;
            r_c_r      <= r_r_final;
        end
    end
`else
    assign w_hit   = 1'b0;
    assign w_hit_q = 32'd0;
    assign w_hit_r = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_valid      = 1'b0;
        o_result     = 32'd0;
        case (r_state)
            ST_IDLE: begin
                o_busy = w_accept;
                if (w_accept) begin
                    w_state_next = (w_div_zero || w_overflow || w_hit) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                o_busy = 1'b1;
                if (w_calc_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_busy       = 1'b1;
                o_valid      = !i_flush;
                o_result     = i_flush ? 32'd0 : (r_is_rem ? r_r_final : r_q_final);
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (i_flush) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= 5'd0;
            r_rs1     <= 32'd0;
            r_rs2     <= 32'd0;
            r_signed  <= 1'b0;
            r_is_rem  <= 1'b0;
            r_rem     <= 32'd0;
            r_quot    <= 32'd0;
            r_divisor <= 32'd0;
            r_q_final <= 32'd0;
            r_r_final <= 32'd0;
        end else if (w_accept) begin
            r_count   <= 5'd0;
            r_rs1     <= i_rs1;
            r_rs2     <= i_rs2;
            r_signed  <= w_signed;
            r_is_rem  <= w_is_rem;
            r_rem     <= 32'd0;
            r_quot    <= abs_if_signed(i_rs1, w_signed);
            r_divisor <= abs_if_signed(i_rs2, w_signed);
            if (w_div_zero) begin
                r_q_final <= 32'hFFFF_FFFF;
                r_r_final <= i_rs1;
            end else if (w_overflow) begin
                r_q_final <= 32'h8000_0000;
                r_r_final <= 32'd0;
            end else if (w_hit) begin
                r_q_final <= w_hit_q;
                r_r_final <= w_hit_r;
            end
        end else if (r_state == ST_CALC && !i_flush) begin
            r_rem   <= w_rem_next;
            r_quot  <= w_quot_next;
            r_count <= r_count + 5'd1;
            // Final iteration: apply RISC-V sign rules to the magnitudes.
            if (w_calc_last) begin
                r_q_final <= w_neg_q ? (~w_quot_next + 32'd1) : w_quot_next;
                r_r_final <= w_neg_r ? (~w_rem_next + 32'd1) : w_rem_next;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rv32m_div_sequencer.sv
// ============================================================================
// Module      : tb_rv32m_div_sequencer
// Description : Self-checking bench for rv32m_div_sequencer (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32m_div_sequencer;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic [2:0]  i_funct3;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic        i_flush;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_result;

    int n_vec;
    int n_err;

    // Reference cache state: last delivered (dividend, divisor, signedness).
    bit          m_c_valid;
    logic [31:0] m_c_rs1;
    logic [31:0] m_c_rs2;
    bit          m_c_signed;

    rv32m_div_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .i_funct3 (i_funct3),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_flush  (i_flush),
        .o_busy   (o_busy),
        .o_valid  (o_valid),
        .o_result (o_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_signed_op(input logic [2:0] f3);
        return (f3 == 3'b100) || (f3 == 3'b110);
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit          sg;
        bit          rm;
        logic [31:0] q;
        logic [31:0] r;
        sg = is_signed_op(f3);
        rm = (f3 == 3'b110) || (f3 == 3'b111);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sg) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return rm ? r : q;
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit sg;
        sg = is_signed_op(f3);
        if (b == 32'd0) return 1;
        if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_RESULT_CACHE_EN
        if (m_c_valid && a == m_c_rs1 && b == m_c_rs2 && sg == m_c_signed) return 1;
`endif
        return 33;
    endfunction

    // Issue one request and wait for its result; churn keeps i_valid high
    // with changing operands while the op is in flight.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input bit churn);
        logic [31:0] exp_res;
        int          exp_lat;
        int          lat;
        bit          got;
        exp_res = ref_result(f3, a, b);
        exp_lat = ref_latency(f3, a, b);
        @(negedge clk);
        i_valid  = 1'b1;
        i_funct3 = f3;
        i_rs1    = a;
        i_rs2    = b;
        #1;
        chk({tag, ".busy_req"}, 32'(o_busy), 32'd1);
        @(posedge clk);
        #1;
        if (!churn) i_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (lat < 40 && !got) begin
            @(negedge clk);
            lat++;
            if (o_valid === 1'b1) begin
                got = 1'b1;
                chk({tag, ".result"}, o_result, exp_res);
                i_valid = 1'b0;
            end else if (churn) begin
                i_rs1    = $urandom;
                i_rs2    = $urandom;
                i_funct3 = 3'($urandom_range(7, 0));
            end
        end
        i_valid = 1'b0;
        chk({tag, ".done"}, 32'(got), 32'd1);
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        @(negedge clk);
        chk({tag, ".valid_drop"}, {31'd0, o_valid}, 32'd0);
        chk({tag, ".result_zero"}, o_result, 32'd0);
        m_c_valid  = 1'b1;
        m_c_rs1    = a;
        m_c_rs2    = b;
        m_c_signed = is_signed_op(f3);
    endtask

    task automatic expect_silence(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (o_valid !== 1'b0) pulses++;
        end
        chk({tag, ".no_valid"}, 32'(pulses), 32'd0);
    endtask

    // Accept a long op and return at the negedge of the given CALC cycle.
    task automatic start_and_wait(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b, input int cycles);
        @(negedge clk);
        i_valid  = 1'b1;
        i_funct3 = f3;
        i_rs1    = a;
        i_rs2    = b;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        m_c_valid = 1'b0;
        m_c_rs1   = 32'd0;
        m_c_rs2   = 32'd0;
        m_c_signed = 1'b0;
        rst      = 1'b1;
        i_valid  = 1'b0;
        i_funct3 = 3'b000;
        i_rs1    = 32'd0;
        i_rs2    = 32'd0;
        i_flush  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.busy", 32'(o_busy), 32'd0);
        chk("reset.valid", 32'(o_valid), 32'd0);
        chk("reset.result", o_result, 32'd0);
        rst = 1'b0;

        run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 1'b0);
        run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 1'b0);
        run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("div_by_zero", 3'b100, 32'h1234_5678, 32'd0, 1'b0);
        run_op("remu_by_zero", 3'b111, 32'hDEAD_BEEF, 32'd0, 1'b0);
        run_op("rem_overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("div_overflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("div_1000_3", 3'b100, 32'd1000, 32'd3, 1'b0);
        run_op("rem_1000_3", 3'b110, 32'd1000, 32'd3, 1'b0);
        run_op("funct3_0xx", 3'b010, 32'hF000_0001, 32'd16, 1'b0);
        run_op("churn", 3'b100, 32'h8765_4321, 32'h0000_0123, 1'b1);

        // Flush in CALC cycle 10.
        start_and_wait(3'b101, 32'd99999, 32'd13, 10);
        i_flush = 1'b1;
        #1;
        chk("flush_calc.valid", 32'(o_valid), 32'd0);
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        chk("flush_calc.busy", 32'(o_busy), 32'd0);
        expect_silence("flush_calc", 40);

        // Flush while the result is on the output.
        start_and_wait(3'b110, 32'h7FFF_0000, 32'h0000_0777, 33);
        i_flush = 1'b1;
        #1;
        chk("flush_done.valid", 32'(o_valid), 32'd0);
        chk("flush_done.result", o_result, 32'd0);
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        expect_silence("flush_done", 5);
        run_op("after_flush_done", 3'b110, 32'h7FFF_0000, 32'h0000_0777, 1'b0);

        // Flush wins over a simultaneous request.
        @(negedge clk);
        i_valid = 1'b1;
        i_flush = 1'b1;
        i_funct3 = 3'b101;
        i_rs1 = 32'd50;
        i_rs2 = 32'd5;
        #1;
        chk("flush_vs_valid.busy", 32'(o_busy), 32'd0);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_flush = 1'b0;
        chk("flush_vs_valid.idle", 32'(o_busy), 32'd0);
        expect_silence("flush_vs_valid", 40);

        // Reset in CALC cycle 20 of a new op.
        start_and_wait(3'b100, 32'h1111_2222, 32'd9, 20);
        rst = 1'b1;
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_calc.busy", 32'(o_busy), 32'd0);
        chk("rst_calc.valid", 32'(o_valid), 32'd0);
        chk("rst_calc.result", o_result, 32'd0);
        rst = 1'b0;
        i_flush = 1'b0;
        m_c_valid = 1'b0;
        expect_silence("rst_calc", 40);
        run_op("after_rst_rem", 3'b110, 32'd1000, 32'd3, 1'b0);

        // Random operations; the second of each pair reuses the operands.
        for (int n = 0; n < 10; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [2:0]  f;
            a = $urandom;
            b = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(9, 0)) : 32'($urandom);
            if ($urandom_range(1, 0) == 1) b = b >> $urandom_range(31, 0);
            f = 3'($urandom_range(7, 0));
            run_op("rand_a", f, a, b, 1'b0);
            run_op("rand_b", {f[2:1], ~f[0]} ^ 3'b010, a, b, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
